// File: rtl/mycpu_id_stage.sv
// Decode stage of the five-stage MIPS pipeline: instruction decode, operand
// forwarding, load-use interlock, branch/jump resolution and the ID->EX register.
module mycpu_id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_rdata,
  input  logic [31:0] IF2ID_pc,
  output logic [31:0] offset,
  output logic [1:0]  jmp_mode,
  output logic        allow_in,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        ex_wen,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_dest,
  input  logic [31:0] ex_result,
  input  logic        mem_wen,
  input  logic [4:0]  mem_dest,
  input  logic [31:0] mem_result,
  input  logic        wb_wen,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_result,
  input  logic        ex_allow_in,
  output logic        ID2EX_valid,
  output logic [31:0] ID2EX_pc,
  output logic [3:0]  ID2EX_alu_op,
  output logic [31:0] ID2EX_src1,
  output logic [31:0] ID2EX_src2,
  output logic [31:0] ID2EX_store_data,
  output logic [4:0]  ID2EX_dest,
  output logic        ID2EX_wen,
  output logic        ID2EX_mem_en,
  output logic        ID2EX_mem_wen
);

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLT = 4'd2, ALU_SLTU = 4'd3,
                         ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                         ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;

  logic        r_id_valid, r_use_buf;
  logic [31:0] r_inst_buf;
  logic        r_valid, r_wen, r_mem_en, r_mem_wen;
  logic [31:0] r_pc, r_src1, r_src2, r_store_data;
  logic [3:0]  r_alu_op;
  logic [4:0]  r_dest;

  logic [31:0] w_inst, w_imm_sext, w_rs_val, w_rt_val, w_src1, w_src2;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_sa, w_dest;
  logic [15:0] w_imm;
  logic [3:0]  w_alu_op, w_pc4_hi;
  logic        w_wen, w_mem_en, w_mem_wen, w_rt_used, w_r_alu, w_shift;
  logic        w_is_beq, w_is_bne, w_is_j, w_is_jr, w_stall, w_issue, w_fire;
  logic [4:0]  w_src_addr [2];
  logic [31:0] w_rf_data  [2];
  logic [31:0] w_fwd      [2];

  // A stalled instruction is replayed from the buffer because the SRAM output may move on.
  assign w_inst     = r_use_buf ? r_inst_buf : inst_sram_rdata;
  assign w_op       = w_inst[31:26];
  assign w_rs       = w_inst[25:21];
  assign w_rt       = w_inst[20:16];
  assign w_rd       = w_inst[15:11];
  assign w_sa       = w_inst[10:6];
  assign w_funct    = w_inst[5:0];
  assign w_imm      = w_inst[15:0];
  assign w_imm_sext = {{16{w_imm[15]}}, w_imm};
  // Upper nibble of pc+4 without building the full adder.
  assign w_pc4_hi   = IF2ID_pc[31:28] + {3'b000, &IF2ID_pc[27:2]};

  assign rf_raddr1     = w_rs;
  assign rf_raddr2     = w_rt;
  assign w_src_addr[0] = w_rs;
  assign w_src_addr[1] = w_rt;
  assign w_rf_data[0]  = rf_rdata1;
  assign w_rf_data[1]  = rf_rdata2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      // Youngest producer wins: EX, then MEM, then WB, then the register file; $0 is hard zero.
      always_comb begin
        w_fwd[gi] = w_rf_data[gi];
        if (w_src_addr[gi] == 5'd0)                          w_fwd[gi] = 32'd0;
        else if (ex_wen  && (ex_dest  == w_src_addr[gi]))   w_fwd[gi] = ex_result;
        else if (mem_wen && (mem_dest == w_src_addr[gi]))   w_fwd[gi] = mem_result;
        else if (wb_wen  && (wb_dest  == w_src_addr[gi]))   w_fwd[gi] = wb_result;
      end
    end
  endgenerate

  assign w_rs_val = w_fwd[0];
  assign w_rt_val = w_fwd[1];

  // Instruction decode into the EX bundle and branch-class flags.
  always_comb begin
    w_alu_op = ALU_ADD;  w_src1 = w_rs_val;  w_src2 = w_rt_val;  w_dest = w_rt;
    w_wen = 1'b0;  w_mem_en = 1'b0;  w_mem_wen = 1'b0;  w_rt_used = 1'b0;
    w_r_alu = 1'b0;  w_shift = 1'b0;
    w_is_beq = 1'b0;  w_is_bne = 1'b0;  w_is_j = 1'b0;  w_is_jr = 1'b0;
    case (w_op)
      6'h00: begin
        w_dest  = w_rd;
        w_r_alu = 1'b1;
        case (w_funct)
          6'h21: w_alu_op = ALU_ADD;
          6'h23: w_alu_op = ALU_SUB;
          6'h2A: w_alu_op = ALU_SLT;
          6'h2B: w_alu_op = ALU_SLTU;
          6'h24: w_alu_op = ALU_AND;
          6'h25: w_alu_op = ALU_OR;
          6'h26: w_alu_op = ALU_XOR;
          6'h27: w_alu_op = ALU_NOR;
          6'h00: begin w_alu_op = ALU_SLL; w_shift = 1'b1; end
          6'h02: begin w_alu_op = ALU_SRL; w_shift = 1'b1; end
          6'h03: begin w_alu_op = ALU_SRA; w_shift = 1'b1; end
          6'h08: begin w_r_alu = 1'b0; w_is_jr = 1'b1; end
          default: w_r_alu = 1'b0;
        endcase
        w_wen     = w_r_alu;
        w_rt_used = w_r_alu;
        if (w_shift) w_src1 = {27'd0, w_sa};
      end
      6'h09: begin w_wen = 1'b1; w_src2 = w_imm_sext; end
      6'h0F: begin w_wen = 1'b1; w_alu_op = ALU_LUI; w_src2 = {16'd0, w_imm}; end
      6'h23: begin w_wen = 1'b1; w_mem_en = 1'b1; w_src2 = w_imm_sext; end
      6'h2B: begin w_mem_en = 1'b1; w_mem_wen = 1'b1; w_src2 = w_imm_sext; w_rt_used = 1'b1; end
      6'h04: begin w_is_beq = 1'b1; w_rt_used = 1'b1; end
      6'h05: begin w_is_bne = 1'b1; w_rt_used = 1'b1; end
      6'h02: w_is_j = 1'b1;
      6'h03: begin w_is_j = 1'b1; w_wen = 1'b1; w_dest = 5'd31; w_src1 = IF2ID_pc; w_src2 = 32'd8; end
      default: ;
    endcase
  end

  // Load-use interlock and handshake toward fetch.
  assign w_stall  = r_id_valid & ex_wen & ex_is_load & (ex_dest != 5'd0) &
                    ((ex_dest == w_rs) | (w_rt_used & (ex_dest == w_rt)));
  assign allow_in = ~r_id_valid | (ex_allow_in & ~w_stall);
  assign w_issue  = r_id_valid & ~w_stall;
  assign w_fire   = w_issue & ex_allow_in;

  // Branch/jump redirect, only for an instruction actually leaving ID this cycle.
  always_comb begin
    jmp_mode = 2'b00;
    offset   = 32'd0;
    if (w_fire) begin
      if ((w_is_beq && (w_rs_val == w_rt_val)) || (w_is_bne && (w_rs_val != w_rt_val))) begin
        jmp_mode = 2'b01;
        offset   = {w_imm_sext[29:0], 2'b00} + 32'd4;
      end else if (w_is_j) begin
        jmp_mode = 2'b10;
        offset   = {w_pc4_hi, w_inst[25:0], 2'b00};
      end else if (w_is_jr) begin
        jmp_mode = 2'b11;
        offset   = w_rs_val;
      end
    end
  end

  // ID valid flag and stall buffer capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id_valid <= 1'b0;
      r_use_buf  <= 1'b0;
      r_inst_buf <= 32'd0;
    end else if (allow_in) begin
      r_id_valid <= inst_sram_en;
      r_use_buf  <= 1'b0;
    end else if (r_id_valid && !r_use_buf) begin
      r_inst_buf <= inst_sram_rdata;
      r_use_buf  <= 1'b1;
    end
  end

  // ID->EX pipeline register; payload holds across bubbles and backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;  r_pc <= 32'd0;  r_alu_op <= 4'd0;
      r_src1 <= 32'd0;  r_src2 <= 32'd0;  r_store_data <= 32'd0;
      r_dest <= 5'd0;  r_wen <= 1'b0;  r_mem_en <= 1'b0;  r_mem_wen <= 1'b0;
    end else if (ex_allow_in) begin
      r_valid <= w_issue;
      if (w_issue) begin
        r_pc <= IF2ID_pc;  r_alu_op <= w_alu_op;
        r_src1 <= w_src1;  r_src2 <= w_src2;  r_store_data <= w_rt_val;
        r_dest <= w_dest;  r_wen <= w_wen;  r_mem_en <= w_mem_en;  r_mem_wen <= w_mem_wen;
      end
    end
  end

  assign ID2EX_valid      = r_valid;
  assign ID2EX_pc         = r_pc;
  assign ID2EX_alu_op     = r_alu_op;
  assign ID2EX_src1       = r_src1;
  assign ID2EX_src2       = r_src2;
  assign ID2EX_store_data = r_store_data;
  assign ID2EX_dest       = r_dest;
  assign ID2EX_wen        = r_wen;
  assign ID2EX_mem_en     = r_mem_en;
  assign ID2EX_mem_wen    = r_mem_wen;

endmodule

// File: tb/tb_mycpu_id_stage.sv
// Testbench for mycpu_id_stage: scoreboard of expected ID2EX bundles plus
// per-scenario checks of the combinational fetch-side outputs.
module tb_mycpu_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [31:0] inst_sram_rdata, IF2ID_pc;
  logic [31:0] offset;
  logic [1:0]  jmp_mode;
  logic        allow_in;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        ex_wen, ex_is_load, mem_wen, wb_wen, ex_allow_in;
  logic [4:0]  ex_dest, mem_dest, wb_dest;
  logic [31:0] ex_result, mem_result, wb_result;
  logic        ID2EX_valid, ID2EX_wen, ID2EX_mem_en, ID2EX_mem_wen;
  logic [31:0] ID2EX_pc, ID2EX_src1, ID2EX_src2, ID2EX_store_data;
  logic [3:0]  ID2EX_alu_op;
  logic [4:0]  ID2EX_dest;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  alu;
    logic [31:0] s1, s2, sd;
    logic [4:0]  dest;
    logic        wen, men, mwen;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic ok;

  always #5 clk = ~clk;

  // Register file stand-in: register n reads C0DE00nn (including $0, which the DUT must zero).
  assign rf_rdata1 = 32'hC0DE0000 | {27'd0, rf_raddr1};
  assign rf_rdata2 = 32'hC0DE0000 | {27'd0, rf_raddr2};

  mycpu_id_stage dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_rdata(inst_sram_rdata), .IF2ID_pc(IF2ID_pc),
    .offset(offset), .jmp_mode(jmp_mode), .allow_in(allow_in),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_dest(ex_dest), .ex_result(ex_result),
    .mem_wen(mem_wen), .mem_dest(mem_dest), .mem_result(mem_result),
    .wb_wen(wb_wen), .wb_dest(wb_dest), .wb_result(wb_result),
    .ex_allow_in(ex_allow_in),
    .ID2EX_valid(ID2EX_valid), .ID2EX_pc(ID2EX_pc), .ID2EX_alu_op(ID2EX_alu_op),
    .ID2EX_src1(ID2EX_src1), .ID2EX_src2(ID2EX_src2), .ID2EX_store_data(ID2EX_store_data),
    .ID2EX_dest(ID2EX_dest), .ID2EX_wen(ID2EX_wen), .ID2EX_mem_en(ID2EX_mem_en),
    .ID2EX_mem_wen(ID2EX_mem_wen)
  );

  // Scoreboard consumer: every newly loaded ID2EX bundle must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (rst && ex_allow_in && ID2EX_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: ID2EX issued pc=%h, required no issue", ID2EX_pc);
      end else begin
        e  = sb.pop_front();
        ok = (ID2EX_pc === e.pc) && (ID2EX_store_data === e.sd) && (ID2EX_wen === e.wen) &&
             (ID2EX_mem_en === e.men) && (ID2EX_mem_wen === e.mwen);
        if (e.wen || e.men)
          ok = ok && (ID2EX_alu_op === e.alu) && (ID2EX_src1 === e.s1) &&
               (ID2EX_src2 === e.s2) && (ID2EX_dest === e.dest);
        if (!ok) begin
          n_fail++;
          $display("FAIL sb_bundle: got pc=%h alu=%0d s1=%h s2=%h sd=%h dest=%0d w/me/mw=%b%b%b, want pc=%h alu=%0d s1=%h s2=%h sd=%h dest=%0d w/me/mw=%b%b%b",
                   ID2EX_pc, ID2EX_alu_op, ID2EX_src1, ID2EX_src2, ID2EX_store_data, ID2EX_dest,
                   ID2EX_wen, ID2EX_mem_en, ID2EX_mem_wen,
                   e.pc, e.alu, e.s1, e.s2, e.sd, e.dest, e.wen, e.men, e.mwen);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic en);
    inst_sram_rdata = inst;
    IF2ID_pc        = pc;
    inst_sram_en    = en;
  endtask

  task automatic push(input logic [31:0] pc, input logic [3:0] alu, input logic [31:0] s1,
                      input logic [31:0] s2, input logic [31:0] sd, input logic [4:0] dest,
                      input logic wen, input logic men, input logic mwen);
    exp_t x;
    x.pc = pc; x.alu = alu; x.s1 = s1; x.s2 = s2; x.sd = sd;
    x.dest = dest; x.wen = wen; x.men = men; x.mwen = mwen;
    sb.push_back(x);
  endtask

  task automatic clear_side();
    ex_wen = 0; ex_is_load = 0; ex_dest = 0; ex_result = 0;
    mem_wen = 0; mem_dest = 0; mem_result = 0;
    wb_wen = 0; wb_dest = 0; wb_result = 0;
  endtask

  // Fetch issues a request so the next cycle has a valid instruction in ID.
  task automatic prime();
    @(negedge clk);
    drive(32'h0, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ID2EX_valid, ID2EX_pc, ID2EX_alu_op, ID2EX_src1, ID2EX_src2, ID2EX_store_data,
         ID2EX_dest, ID2EX_wen, ID2EX_mem_en, ID2EX_mem_wen} !== '0) begin
      n_fail++;
      $display("FAIL reset_id2ex: got valid=%b pc=%h src1=%h, want all zero", ID2EX_valid, ID2EX_pc, ID2EX_src1);
    end
    n_cmp++;
    if ({allow_in, jmp_mode, offset} !== {1'b1, 2'b00, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_fetch: got allow_in=%b jmp_mode=%b offset=%h, want 1/00/00000000", allow_in, jmp_mode, offset);
    end
    rst = 1'b1;
  endtask

  task automatic test_sequential();
    prime();
    @(negedge clk);
    drive(32'h24010005, 32'hbfc00000, 1'b0);  // ADDIU $1,$0,5
    push(32'hbfc00000, 4'd0, 32'h0, 32'h5, 32'hC0DE0001, 5'd1, 1, 0, 0);
    #1;
    n_cmp++;
    if ({allow_in, jmp_mode, offset, rf_raddr1, rf_raddr2} !== {1'b1, 2'b00, 32'h0, 5'd0, 5'd1}) begin
      n_fail++;
      $display("FAIL seq_comb: got allow_in=%b jmp=%b off=%h ra1=%0d ra2=%0d, want 1/00/0/0/1",
               allow_in, jmp_mode, offset, rf_raddr1, rf_raddr2);
    end
    @(negedge clk);
    n_cmp++;
    if ({ID2EX_valid, ID2EX_pc} !== {1'b1, 32'hbfc00000}) begin
      n_fail++;
      $display("FAIL seq_latency: got valid=%b pc=%h, want 1/bfc00000", ID2EX_valid, ID2EX_pc);
    end
    drive(32'hFFFFFFFF, 32'hbfc00004, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (ID2EX_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_empty: got valid=%b, want 0", ID2EX_valid);
    end
  endtask

  task automatic test_branch();
    prime();
    @(negedge clk);
    drive(32'h10000003, 32'h100, 1'b1);  // BEQ $0,$0,3
    push(32'h100, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    #1;
    n_cmp++;
    if ({jmp_mode, offset} !== {2'b01, 32'h10}) begin
      n_fail++;
      $display("FAIL beq_taken: got jmp=%b off=%h, want 01/00000010", jmp_mode, offset);
    end
    @(negedge clk);
    drive(32'h24050007, 32'h104, 1'b1);  // delay slot ADDIU $5,$0,7
    push(32'h104, 4'd0, 32'h0, 32'h7, 32'hC0DE0005, 5'd5, 1, 0, 0);
    #1;
    n_cmp++;
    if ({jmp_mode, offset} !== {2'b00, 32'h0}) begin
      n_fail++;
      $display("FAIL slot_seq: got jmp=%b off=%h, want 00/00000000", jmp_mode, offset);
    end
    @(negedge clk);
    drive(32'h14000003, 32'h108, 1'b0);  // BNE $0,$0,3 (not taken)
    push(32'h108, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    #1;
    n_cmp++;
    if ({jmp_mode, offset} !== {2'b00, 32'h0}) begin
      n_fail++;
      $display("FAIL bne_not_taken: got jmp=%b off=%h, want 00/00000000", jmp_mode, offset);
    end
    @(negedge clk);
    n_cmp++;
    if ({ID2EX_valid, ID2EX_pc} !== {1'b1, 32'h108}) begin
      n_fail++;
      $display("FAIL branch_stream: got valid=%b pc=%h, want 1/00000108", ID2EX_valid, ID2EX_pc);
    end
    drive(32'hFFFFFFFF, 32'h10c, 1'b0);
  endtask

  task automatic test_load_use();
    prime();
    @(negedge clk);
    ex_wen = 1; ex_is_load = 1; ex_dest = 5'd2; ex_result = 32'h0BAD;
    drive(32'h00421821, 32'h200, 1'b1);  // ADDU $3,$2,$2
    #1;
    n_cmp++;
    if ({allow_in, jmp_mode} !== {1'b0, 2'b00}) begin
      n_fail++;
      $display("FAIL lu_stall: got allow_in=%b jmp=%b, want 0/00", allow_in, jmp_mode);
    end
    @(negedge clk);
    n_cmp++;
    if (ID2EX_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_bubble: got valid=%b, want 0", ID2EX_valid);
    end
    clear_side();
    mem_wen = 1; mem_dest = 5'd2; mem_result = 32'h12345678;
    drive(32'hFFFFFFFF, 32'h200, 1'b0);  // SRAM output moved on; buffer must supply ADDU
    push(32'h200, 4'd0, 32'h12345678, 32'h12345678, 32'h12345678, 5'd3, 1, 0, 0);
    #1;
    n_cmp++;
    if (allow_in !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_release: got allow_in=%b, want 1", allow_in);
    end
    @(negedge clk);
    n_cmp++;
    if ({ID2EX_valid, ID2EX_pc} !== {1'b1, 32'h200}) begin
      n_fail++;
      $display("FAIL lu_issue: got valid=%b pc=%h, want 1/00000200", ID2EX_valid, ID2EX_pc);
    end
    clear_side();
  endtask

  task automatic test_forwarding();
    prime();
    @(negedge clk);
    ex_wen = 1; ex_dest = 5'd4; ex_result = 32'hAAAA;
    mem_wen = 1; mem_dest = 5'd4; mem_result = 32'h5555;
    wb_wen = 1; wb_dest = 5'd7; wb_result = 32'h7777;
    drive(32'h00873021, 32'h300, 1'b1);  // ADDU $6,$4,$7
    push(32'h300, 4'd0, 32'hAAAA, 32'h7777, 32'h7777, 5'd6, 1, 0, 0);
    @(negedge clk);
    clear_side();
    ex_wen = 1; ex_dest = 5'd0; ex_result = 32'hAAAA;
    drive(32'h00873021, 32'h304, 1'b1);
    push(32'h304, 4'd0, 32'hC0DE0004, 32'hC0DE0007, 32'hC0DE0007, 5'd6, 1, 0, 0);
    #1;
    n_cmp++;
    if (allow_in !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_no_stall: got allow_in=%b, want 1", allow_in);
    end
    @(negedge clk);
    clear_side();
    mem_wen = 1; mem_dest = 5'd4; mem_result = 32'h5555;
    wb_wen = 1; wb_dest = 5'd4; wb_result = 32'h9999;
    drive(32'h00873021, 32'h308, 1'b0);
    push(32'h308, 4'd0, 32'h5555, 32'hC0DE0007, 32'hC0DE0007, 5'd6, 1, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (ID2EX_pc !== 32'h308) begin
      n_fail++;
      $display("FAIL fwd_stream: got pc=%h, want 00000308", ID2EX_pc);
    end
    clear_side();
  endtask

  task automatic test_alu_table();
    logic [31:0] insts [6];
    exp_t        exps  [6];
    insts[0] = 32'h00095100;  // SLL  $10,$9,4
    insts[1] = 32'h00107FC3;  // SRA  $15,$16,31
    insts[2] = 32'h3C0B1234;  // LUI  $11,0x1234
    insts[3] = 32'h00226023;  // SUBU $12,$1,$2
    insts[4] = 32'h8DCD0008;  // LW   $13,8($14)
    insts[5] = 32'hFC000000;  // unsupported -> NOP
    exps[0] = '{32'h600, 4'd8,  32'd4,        32'hC0DE0009, 32'hC0DE0009, 5'd10, 1'b1, 1'b0, 1'b0};
    exps[1] = '{32'h604, 4'd10, 32'd31,       32'hC0DE0010, 32'hC0DE0010, 5'd15, 1'b1, 1'b0, 1'b0};
    exps[2] = '{32'h608, 4'd11, 32'd0,        32'h1234,     32'hC0DE000B, 5'd11, 1'b1, 1'b0, 1'b0};
    exps[3] = '{32'h60C, 4'd1,  32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0002, 5'd12, 1'b1, 1'b0, 1'b0};
    exps[4] = '{32'h610, 4'd0,  32'hC0DE000E, 32'h8,        32'hC0DE000D, 5'd13, 1'b1, 1'b1, 1'b0};
    exps[5] = '{32'h614, 4'd0,  32'd0,        32'd0,        32'd0,        5'd0,  1'b0, 1'b0, 1'b0};
    prime();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(insts[i], exps[i].pc, (i < 5));
      sb.push_back(exps[i]);
      #1;
      n_cmp++;
      if ({allow_in, jmp_mode, offset} !== {1'b1, 2'b00, 32'h0}) begin
        n_fail++;
        $display("FAIL alu_comb_%0d: got allow_in=%b jmp=%b off=%h, want 1/00/0", i, allow_in, jmp_mode, offset);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({ID2EX_valid, ID2EX_pc} !== {1'b1, 32'h614}) begin
      n_fail++;
      $display("FAIL alu_stream: got valid=%b pc=%h, want 1/00000614", ID2EX_valid, ID2EX_pc);
    end
  endtask

  task automatic test_jal_jr();
    prime();
    @(negedge clk);
    drive(32'h0C000040, 32'hbfc00010, 1'b1);  // JAL 0x40
    push(32'hbfc00010, 4'd0, 32'hbfc00010, 32'h8, 32'h0, 5'd31, 1, 0, 0);
    #1;
    n_cmp++;
    if ({jmp_mode, offset} !== {2'b10, 32'hb0000100}) begin
      n_fail++;
      $display("FAIL jal_target: got jmp=%b off=%h, want 10/b0000100", jmp_mode, offset);
    end
    @(negedge clk);
    ex_wen = 1; ex_dest = 5'd31; ex_result = 32'h1234;
    drive(32'h03E00008, 32'hbfc00014, 1'b0);  // JR $31
    push(32'hbfc00014, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    #1;
    n_cmp++;
    if ({jmp_mode, offset} !== {2'b11, 32'h1234}) begin
      n_fail++;
      $display("FAIL jr_target: got jmp=%b off=%h, want 11/00001234", jmp_mode, offset);
    end
    @(negedge clk);
    clear_side();
    n_cmp++;
    if (ID2EX_pc !== 32'hbfc00014) begin
      n_fail++;
      $display("FAIL jr_issue: got pc=%h, want bfc00014", ID2EX_pc);
    end
  endtask

  task automatic test_backpressure();
    prime();
    @(negedge clk);
    drive(32'hACC5FFFC, 32'h400, 1'b1);  // SW $5,-4($6)
    push(32'h400, 4'd0, 32'hC0DE0006, 32'hFFFFFFFC, 32'hC0DE0005, 5'd5, 0, 1, 1);
    @(negedge clk);
    ex_allow_in = 1'b0;
    drive(32'h10000003, 32'h404, 1'b1);  // BEQ $0,$0,3 held by backpressure
    #1;
    n_cmp++;
    if ({allow_in, jmp_mode, offset} !== {1'b0, 2'b00, 32'h0}) begin
      n_fail++;
      $display("FAIL bp_hold: got allow_in=%b jmp=%b off=%h, want 0/00/0", allow_in, jmp_mode, offset);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(32'hFFFFFFFF, 32'h404, 1'b1);
      #1;
      n_cmp++;
      if ({allow_in, jmp_mode, ID2EX_valid, ID2EX_pc} !== {1'b0, 2'b00, 1'b1, 32'h400}) begin
        n_fail++;
        $display("FAIL bp_frozen_%0d: got allow_in=%b jmp=%b valid=%b pc=%h, want 0/00/1/00000400",
                 c, allow_in, jmp_mode, ID2EX_valid, ID2EX_pc);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({ID2EX_valid, ID2EX_pc} !== {1'b1, 32'h400}) begin
      n_fail++;
      $display("FAIL bp_frozen_end: got valid=%b pc=%h, want 1/00000400", ID2EX_valid, ID2EX_pc);
    end
    ex_allow_in = 1'b1;
    drive(32'hFFFFFFFF, 32'h404, 1'b0);
    push(32'h404, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    #1;
    n_cmp++;
    if ({allow_in, jmp_mode, offset} !== {1'b1, 2'b01, 32'h10}) begin
      n_fail++;
      $display("FAIL bp_release: got allow_in=%b jmp=%b off=%h, want 1/01/00000010", allow_in, jmp_mode, offset);
    end
    @(negedge clk);
    n_cmp++;
    if ({ID2EX_valid, ID2EX_pc} !== {1'b1, 32'h404}) begin
      n_fail++;
      $display("FAIL bp_issue: got valid=%b pc=%h, want 1/00000404", ID2EX_valid, ID2EX_pc);
    end
  endtask

  task automatic test_reset_mid_stall();
    prime();
    @(negedge clk);
    drive(32'h24010005, 32'h500, 1'b1);
    push(32'h500, 4'd0, 32'h0, 32'h5, 32'hC0DE0001, 5'd1, 1, 0, 0);
    @(negedge clk);
    ex_allow_in = 1'b0;
    ex_wen = 1; ex_is_load = 1; ex_dest = 5'd2;
    drive(32'h00421821, 32'h504, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({ID2EX_valid, ID2EX_pc, ID2EX_src1, ID2EX_src2, ID2EX_store_data, ID2EX_dest,
         ID2EX_wen, ID2EX_mem_en, ID2EX_mem_wen, ID2EX_alu_op} !== '0) begin
      n_fail++;
      $display("FAIL rst_async_id2ex: got valid=%b pc=%h src2=%h, want all zero", ID2EX_valid, ID2EX_pc, ID2EX_src2);
    end
    n_cmp++;
    if ({allow_in, jmp_mode, offset} !== {1'b1, 2'b00, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_async_fetch: got allow_in=%b jmp=%b off=%h, want 1/00/0", allow_in, jmp_mode, offset);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_side();
    ex_allow_in = 1'b1;
    drive(32'h00421821, 32'h504, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (ID2EX_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_drop: got valid=%b, want 0 (pending instruction dropped)", ID2EX_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_side();
    ex_allow_in = 1'b1;
    drive(32'h0, 32'h0, 1'b0);
    test_reset();
    test_sequential();
    test_branch();
    test_load_use();
    test_forwarding();
    test_alu_table();
    test_jal_jr();
    test_backpressure();
    test_reset_mid_stall();
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
